// File: rtl/rename_pkg.sv
// Shared constants and types for the rename-stage physical register free list.
package rename_pkg;

    localparam int unsigned PREG_NUM = 64;
    localparam int unsigned LREG_NUM = 32;
    localparam int unsigned WIDTH    = 2;
    localparam int unsigned PREG_W   = 6;
    localparam int unsigned FL_DEPTH = PREG_NUM - LREG_NUM;
    localparam int unsigned IDX_W    = PREG_W - 1;
    localparam int unsigned CNT_W    = $clog2(WIDTH + 1);

    typedef logic [PREG_W-1:0] preg_t;
    // Free-list pointer: {wrap bit, IDX_W-bit index}; kept as a flat vector so
    // plain modulo-2*DEPTH arithmetic works on it directly.
    typedef logic [PREG_W-1:0] fl_ptr_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    // Buffer index of the entry 'off' places past pointer 'base' (wraps mod DEPTH).
    function automatic logic [IDX_W-1:0] slot_idx(fl_ptr_t base, cnt_t off);
        return base[IDX_W-1:0] + IDX_W'(off);
    endfunction

endpackage

// File: rtl/rename_freelist_if.sv
// Alloc / commit / flush signal bundle between rename and the free list.
interface rename_freelist_if;
    import rename_pkg::*;

    logic [WIDTH-1:0]        alloc_req;
    logic                    alloc_ready;
    logic [WIDTH*PREG_W-1:0] alloc_pdst;
    logic [WIDTH-1:0]        commit_valid;
    logic [WIDTH*PREG_W-1:0] commit_old_pdst;
    logic                    flush;
    logic [PREG_W-1:0]       free_count;

    // Rename / commit side
    modport master (
        output alloc_req, commit_valid, commit_old_pdst, flush,
        input  alloc_ready, alloc_pdst, free_count
    );

    // Free-list side
    modport slave (
        input  alloc_req, commit_valid, commit_old_pdst, flush,
        output alloc_ready, alloc_pdst, free_count
    );

endinterface

// File: rtl/fl_compact.sv
// Converts a per-slot valid mask into compacted per-slot offsets and a popcount.
module fl_compact
    import rename_pkg::*;
(
    input  logic [WIDTH-1:0]       i_mask,
    output cnt_t [WIDTH-1:0]       o_off,
    output cnt_t                   o_cnt
);

    cnt_t w_acc;

    // Each slot's offset is the number of valid slots below it.
    always_comb begin
        w_acc = '0;
        o_off = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            o_off[i] = w_acc;
            w_acc    = w_acc + cnt_t'(i_mask[i]);
        end
        o_cnt = w_acc;
    end

endmodule

// File: rtl/rename_freelist.sv
// Physical register free list: circular buffer with speculative head,
// committed head and tail pointers for a WIDTH-wide rename stage.
module rename_freelist
    import rename_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    rename_freelist_if.slave  fl
);

    preg_t   r_entry [FL_DEPTH];
    fl_ptr_t r_spec_head;
    fl_ptr_t r_commit_head;
    fl_ptr_t r_tail;

    cnt_t [WIDTH-1:0] w_alloc_off;
    cnt_t [WIDTH-1:0] w_commit_off;
    cnt_t             w_alloc_cnt;
    cnt_t             w_commit_cnt;
    fl_ptr_t          w_free_cnt;
    logic             w_ready;
    logic             w_fire;

    fl_compact u_alloc_cmp (
        .i_mask (fl.alloc_req),
        .o_off  (w_alloc_off),
        .o_cnt  (w_alloc_cnt)
    );

    fl_compact u_commit_cmp (
        .i_mask (fl.commit_valid),
        .o_off  (w_commit_off),
        .o_cnt  (w_commit_cnt)
    );

    assign w_free_cnt     = r_tail - r_spec_head;
    assign w_ready        = fl_ptr_t'(w_alloc_cnt) <= w_free_cnt;
    assign w_fire         = (|fl.alloc_req) & w_ready & ~fl.flush;
    assign fl.alloc_ready = w_ready;
    assign fl.free_count  = w_free_cnt;

    // Grant compacted entries from the speculative head; idle slots read zero.
    always_comb begin
        fl.alloc_pdst = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (fl.alloc_req[i]) begin
                fl.alloc_pdst[i*PREG_W +: PREG_W] = r_entry[slot_idx(r_spec_head, w_alloc_off[i])];
            end
        end
    end

    // Buffer storage: initial free registers on reset, reclaimed registers at the tail on commit.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned k = 0; k < FL_DEPTH; k++) begin
                r_entry[k] <= preg_t'(LREG_NUM + k);
            end
        end else begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (fl.commit_valid[i]) begin
                    r_entry[slot_idx(r_tail, w_commit_off[i])] <= fl.commit_old_pdst[i*PREG_W +: PREG_W];
                end
            end
        end
    end

    // Pointer update; a flush rewinds the speculative head to the post-commit head.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_spec_head   <= '0;
            r_commit_head <= '0;
            r_tail        <= fl_ptr_t'(FL_DEPTH);
        end else begin
            r_tail        <= r_tail + fl_ptr_t'(w_commit_cnt);
            r_commit_head <= r_commit_head + fl_ptr_t'(w_commit_cnt);
            if (fl.flush) begin
                r_spec_head <= r_commit_head + fl_ptr_t'(w_commit_cnt);
            end else if (w_fire) begin
                r_spec_head <= r_spec_head + fl_ptr_t'(w_alloc_cnt);
            end
        end
    end

    // Occupancy and commit-ordering sanity checks.
    always_ff @(posedge clock) begin
        if (!reset) begin
            assert ((r_tail - r_commit_head) <= fl_ptr_t'(FL_DEPTH))
                else $error("free list holds more than DEPTH entries");
            assert (!((|fl.commit_valid) && (r_commit_head == r_spec_head)))
                else $error("commit with no outstanding allocation");
        end
    end

endmodule

// File: tb/tb_rename_freelist.sv
// Directed plus randomized bench for rename_freelist against a queue model.
module tb_rename_freelist;
    import rename_pkg::*;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    rename_freelist_if fl_if ();

    rename_freelist dut (
        .clock (clock),
        .reset (reset),
        .fl    (fl_if.slave)
    );

    int checks = 0;
    int errors = 0;

    // Model: q holds the free list in order from the committed head to the
    // tail; the first 'so' entries are speculatively handed out.
    int q[$];
    int so;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        fl_if.alloc_req = '0;
        fl_if.commit_valid = '0;
        fl_if.commit_old_pdst = '0;
        fl_if.flush = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        q.delete();
        for (int k = 0; k < 32; k++) q.push_back(32 + k);
        so = 0;
    endtask

    // One clock cycle: drive, check combinational/registered outputs, update model.
    task automatic step(logic [1:0] req, logic [1:0] cv, int old0, int old1, logic fls);
        int nreq, ncv, fc, k, e;
        logic exp_ready, fire;
        fl_if.alloc_req = req;
        fl_if.commit_valid = cv;
        fl_if.commit_old_pdst = {6'(old1), 6'(old0)};
        fl_if.flush = fls;
        @(negedge clock);
        nreq = int'(req[0]) + int'(req[1]);
        ncv  = int'(cv[0]) + int'(cv[1]);
        fc   = q.size() - so;
        exp_ready = (nreq <= fc);
        chk("free_count", 32'(fl_if.free_count), 32'(fc));
        chk("alloc_ready", 32'(fl_if.alloc_ready), 32'(exp_ready));
        if (exp_ready) begin
            k = 0;
            for (int i = 0; i < 2; i++) begin
                e = 0;
                if (req[i]) begin
                    e = q[so + k];
                    k++;
                end
                chk(i == 0 ? "alloc_pdst0" : "alloc_pdst1", 32'(fl_if.alloc_pdst[i*6 +: 6]), 32'(e));
            end
        end
        fire = (req != 2'b00) && exp_ready && !fls;
        for (int i = 0; i < ncv; i++) void'(q.pop_front());
        if (cv[0]) q.push_back(old0);
        if (cv[1]) q.push_back(old1);
        so = so + (fire ? nreq : 0) - ncv;
        if (fls) so = 0;
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int n, mx;
        logic [1:0] r, c;

        // Reset state and plan item 1
        do_reset();
        step(2'b00, 2'b00, 0, 0, 1'b0);
        fl_if.alloc_req = 2'b11;
        #1;
        chk("t1_pdst", 32'(fl_if.alloc_pdst), 32'({6'd33, 6'd32}));
        step(2'b11, 2'b00, 0, 0, 1'b0);
        chk("t1_fc", 32'(fl_if.free_count), 32'd30);

        // Plan item 2: slot1-only request is compacted onto the head entry
        do_reset();
        fl_if.alloc_req = 2'b10;
        #1;
        chk("t2_pdst", 32'(fl_if.alloc_pdst), 32'({6'd32, 6'd0}));
        step(2'b10, 2'b00, 0, 0, 1'b0);
        chk("t2_fc", 32'(fl_if.free_count), 32'd31);

        // Plan item 3: drain to empty, then a refused request
        do_reset();
        for (int i = 0; i < 16; i++) step(2'b11, 2'b00, 0, 0, 1'b0);
        chk("t3_empty", 32'(fl_if.free_count), 32'd0);
        step(2'b01, 2'b00, 0, 0, 1'b0);
        chk("t3_still_empty", 32'(fl_if.free_count), 32'd0);

        // Plan item 4: reclaim {5,7} and reallocate them
        step(2'b00, 2'b11, 7, 5, 1'b0);
        chk("t4_fc", 32'(fl_if.free_count), 32'd2);
        fl_if.alloc_req = 2'b11;
        #1;
        chk("t4_pdst", 32'(fl_if.alloc_pdst), 32'({6'd5, 6'd7}));
        step(2'b11, 2'b00, 0, 0, 1'b0);

        // Plan item 5: alloc 4, commit 1, flush
        do_reset();
        step(2'b11, 2'b00, 0, 0, 1'b0);
        step(2'b11, 2'b00, 0, 0, 1'b0);
        step(2'b00, 2'b01, 3, 0, 1'b0);
        step(2'b00, 2'b00, 0, 0, 1'b1);
        chk("t5_fc", 32'(fl_if.free_count), 32'd32);
        fl_if.alloc_req = 2'b11;
        #1;
        chk("t5_pdst", 32'(fl_if.alloc_pdst), 32'({6'd34, 6'd33}));
        step(2'b11, 2'b00, 0, 0, 1'b0);

        // Plan item 6: flush + alloc + commit in one cycle
        step(2'b11, 2'b01, 9, 0, 1'b1);
        chk("t6_fc", 32'(fl_if.free_count), 32'd32);
        step(2'b00, 2'b00, 0, 0, 1'b0);

        // Plan item 7: cross the wrap bit repeatedly, then full drain/refill
        do_reset();
        for (int i = 0; i < 80; i++) begin
            step(2'b11, 2'b00, 0, 0, 1'b0);
            step(2'b00, 2'b11, $urandom_range(0, 63), $urandom_range(0, 63), 1'b0);
        end
        chk("t7_full", 32'(fl_if.free_count), 32'd32);
        for (int i = 0; i < 16; i++) step(2'b11, 2'b00, 0, 0, 1'b0);
        chk("t7_empty", 32'(fl_if.free_count), 32'd0);
        for (int i = 0; i < 16; i++)
            step(2'b00, 2'b11, $urandom_range(0, 63), $urandom_range(0, 63), 1'b0);
        chk("t7_refull", 32'(fl_if.free_count), 32'd32);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            r  = 2'($urandom_range(0, 3));
            mx = (so < 2) ? so : 2;
            n  = $urandom_range(0, mx);
            c  = (n == 0) ? 2'b00 : (n == 2) ? 2'b11 : ($urandom_range(0, 1) == 1 ? 2'b01 : 2'b10);
            step(r, c, $urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 19) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
